hazard_stall_ctrl: RTL and testbench
====================================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter BR_EXTRA, default 1, meaning extra IF/ID flush cycles after a taken branch (range 0..7).
REQ-002 SHALL have parameter CNT_W, default 16, meaning stall_count width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: asynchronous, active-low.
REQ-006 Port id_rs1_addr / id_rs2_addr, input, 5 each: ID-stage source register numbers.
REQ-007 Port id_uses_rs1 / id_uses_rs2, input, 1 each: the ID instruction reads that source.
REQ-008 Port ex_rd_addr, input, 5: EX-stage destination register.
REQ-009 Port ex_rd_we, input, 1: the EX instruction writes rd.
REQ-010 Port ex_is_load, input, 1: the EX instruction is a load.
REQ-011 Port ex_branch_taken, input, 1: EX resolves a taken branch or jump this cycle.
REQ-012 Port mem_req, input, 1: MEM stage has an outstanding data-memory access.
REQ-013 Port mem_ack, input, 1: data memory completes the access this cycle.
REQ-014 Port stall, output, 5: bit0 PC hold; bit1 IF/ID hold; bit2 ID/EX bubble (zeroes ID/EX); bit3 IF/ID flush; bit4 MEM/WB bubble.
REQ-015 Port freeze, output, 1: global pipeline hold; all pipeline registers keep their value.
REQ-016 Port state, output, 2: FSM state, encoded as RUN=0, MEM_WAIT=1, FLUSH=2.
REQ-017 Port stall_count, output, CNT_W: saturating count of stalled cycles.

Function
REQ-018 stall and freeze SHALL be combinational from the registered state and the current-cycle inputs, so each response applies in the same cycle as its cause.
REQ-019 Priority SHALL be: memory wait, then branch, then load-use; at most one rule is active per cycle.
REQ-020 The memory-wait condition SHALL be mem_req=1 and mem_ack=0.
REQ-021 The load-use condition SHALL be: ex_is_load, ex_rd_we, ex_rd_addr!=0, and (id_uses_rs1 with id_rs1_addr==ex_rd_addr, or id_uses_rs2 with id_rs2_addr==ex_rd_addr).
REQ-022 RUN, memory wait: freeze=1, stall=5'b10000; next state MEM_WAIT.
REQ-023 RUN, ex_branch_taken with no memory wait: stall=5'b01100, PC not held; next state FLUSH with flush_cnt=BR_EXTRA, or RUN if BR_EXTRA=0.
REQ-024 RUN, load-use with no higher-priority rule: stall=5'b00111; next state RUN.
REQ-025 RUN, no condition active: stall=0 and freeze=0.
REQ-026 MEM_WAIT, mem_ack=0: freeze=1, stall=5'b10000; state holds.
REQ-027 MEM_WAIT, mem_ack=1: outputs and next state SHALL follow the RUN rules, with the memory-wait term treated as false.
REQ-028 FLUSH, no memory wait: stall=5'b01000; flush_cnt decrements; when flush_cnt==1, next state is RUN.
REQ-029 FLUSH, memory wait: freeze=1, stall=5'b10000; flush_cnt and state hold.
REQ-030 In FLUSH, ex_branch_taken and load-use SHALL be ignored, because the EX and ID contents are bubbles.
REQ-031 stall_count SHALL increment on every cycle with freeze=1 or stall!=0, and saturate at all-ones without wrapping.
REQ-032 Addresses with x0 as destination SHALL never produce a load-use stall.

Reset
REQ-033 While reset=0: state=RUN, flush_cnt=0, stall_count=0, and stall=0 and freeze=0 regardless of inputs.
REQ-034 Reset asserted mid-MEM_WAIT or mid-FLUSH SHALL abort immediately, with no residual stall after release.
REQ-035 The first rising edge after reset goes high SHALL evaluate the RUN rules.

Verification
REQ-036 Load x5, then ID reads rs2=x5 (id_uses_rs2=1) -> exactly one cycle of stall=00111; stall_count=1.
REQ-037 Load with ex_rd_addr=0, ID reads x0 -> stall=0.
REQ-038 ex_branch_taken=1 with BR_EXTRA=1 -> cycle T stall=01100; T+1 stall=01000 with state=2; T+2 stall=0 with state=0.
REQ-039 mem_req=1 with mem_ack=0 for 3 cycles, then mem_ack=1 -> freeze=1 and stall=10000 for 3 cycles, then freeze=0; stall_count+=3.
REQ-040 mem wait, taken branch, and load-use in the same cycle -> only freeze=1 and stall=10000; after the ack, the branch rule applies if ex_branch_taken is still 1.
REQ-041 CNT_W=4 with 20 stalled cycles -> stall_count=4'hF; reset pulse in FLUSH -> state=0, outputs 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard stall/flush/freeze controller
// Resolves memory-wait, taken-branch and load-use hazards into per-stage hold, bubble and flush controls.
module hazard_stall_ctrl #(
  parameter int unsigned BR_EXTRA = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_rd_we,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic [4:0]       stall,
  output logic             freeze,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  localparam logic [2:0] FLUSH_INIT = 3'(BR_EXTRA);

  localparam logic [4:0] STALL_NONE = 5'b00000;
  localparam logic [4:0] STALL_MEM  = 5'b10000;
  localparam logic [4:0] STALL_BR   = 5'b01100;
  localparam logic [4:0] STALL_LU   = 5'b00111;
  localparam logic [4:0] STALL_FL   = 5'b01000;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic       mem_wait;
  logic       rs1_hit;
  logic       rs2_hit;
  logic       load_use;
  logic       run_eval;
  logic       run_mem_wait;
  logic [4:0] stall_c;
  logic       freeze_c;

  assign mem_wait = mem_req & ~mem_ack;
  assign rs1_hit  = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
  // x0 is hard-wired zero, so a load targeting it never creates a dependency
  assign load_use = ex_is_load && ex_rd_we && (ex_rd_addr != 5'd0) && (rs1_hit || rs2_hit);

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    stall_c      = STALL_NONE;
    freeze_c     = 1'b0;
    run_eval     = 1'b0;
    run_mem_wait = mem_wait;

    case (state_q)
      ST_RUN: begin
        run_eval = 1'b1;
      end
      ST_MEM_WAIT: begin
        if (!mem_ack) begin
          freeze_c = 1'b1;
          stall_c  = STALL_MEM;
        end else begin
          // the completing access releases the pipeline into normal RUN evaluation
          run_eval     = 1'b1;
          run_mem_wait = 1'b0;
        end
      end
      ST_FLUSH: begin
        // EX/ID hold bubbles here, so branch and load-use inputs are meaningless
        if (mem_wait) begin
          freeze_c = 1'b1;
          stall_c  = STALL_MEM;
        end else begin
          stall_c = STALL_FL;
          if (flush_cnt_q <= 3'd1) begin
            state_d     = ST_RUN;
            flush_cnt_d = 3'd0;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = 3'd0;
      end
    endcase

    if (run_eval) begin
      if (run_mem_wait) begin
        freeze_c = 1'b1;
        stall_c  = STALL_MEM;
        state_d  = ST_MEM_WAIT;
      end else if (ex_branch_taken) begin
        stall_c = STALL_BR;
        if (FLUSH_INIT != 3'd0) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_INIT;
        end else begin
          state_d     = ST_RUN;
          flush_cnt_d = 3'd0;
        end
      end else begin
        state_d = ST_RUN;
        if (load_use) begin
          stall_c = STALL_LU;
        end
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if ((freeze_c || (stall_c != STALL_NONE)) && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      flush_cnt_q   <= 3'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  // reset gates the combinational outputs so nothing leaks out while it is held
  assign stall       = reset ? stall_c : STALL_NONE;
  assign freeze      = reset ? freeze_c : 1'b0;
  assign state       = state_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - table-driven scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       br;
    logic       req;
    logic       ack;
    logic [4:0] stall;
    logic       frz;
    logic [1:0] st;
    int         cnt;
  } vec_t;

  typedef struct {
    logic [4:0] stall;
    logic       frz;
    logic [1:0] st;
    int         cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_uses_rs1, id_uses_rs2, ex_rd_we, ex_is_load;
  logic        ex_branch_taken, mem_req, mem_ack;
  logic [4:0]  stall, stall4;
  logic        freeze, freeze4;
  logic [1:0]  state, state4;
  logic [15:0] stall_count;
  logic [3:0]  stall_count4;

  int   checks;
  int   failures;
  vec_t vecs[$];
  exp_t exp_q[$];

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .stall(stall), .freeze(freeze), .state(state), .stall_count(stall_count)
  );

  hazard_stall_ctrl #(.BR_EXTRA(1), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .stall(stall4), .freeze(freeze4), .state(state4), .stall_count(stall_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                              input logic u2, input logic [4:0] rd, input logic we, input logic ld,
                              input logic br, input logic req, input logic ack,
                              input logic [4:0] st5, input logic frz, input logic [1:0] st, input int cnt);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd; v.we = we; v.ld = ld;
    v.br = br; v.req = req; v.ack = ack; v.stall = st5; v.frz = frz; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs1_addr = v.rs1; id_rs2_addr = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_rd_addr = v.rd; ex_rd_we = v.we; ex_is_load = v.ld; ex_branch_taken = v.br;
    mem_req = v.req; mem_ack = v.ack;
  endtask

  // drive one cycle, push its expectation, compare at the falling edge, then move past the next rising edge
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    int   c4;
    drive(v);
    e.stall = v.stall; e.frz = v.frz; e.st = v.st; e.cnt = v.cnt;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    c4 = (e.cnt > 15) ? 15 : e.cnt;
    chk("stall", idx, 32'(stall), 32'(e.stall));
    chk("freeze", idx, 32'(freeze), 32'(e.frz));
    chk("state", idx, 32'(state), 32'(e.st));
    chk("stall_count", idx, 32'(stall_count), 32'(e.cnt));
    chk("stall_count_w4", idx, 32'(stall_count4), 32'(c4));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_quiet(input int idx);
    chk("rst_stall", idx, 32'(stall), 32'd0);
    chk("rst_freeze", idx, 32'(freeze), 32'd0);
    chk("rst_state", idx, 32'(state), 32'd0);
    chk("rst_count", idx, 32'(stall_count), 32'd0);
    chk("rst_count_w4", idx, 32'(stall_count4), 32'd0);
  endtask

  vec_t idle;

  initial begin
    checks = 0;
    failures = 0;
    idle = mk(0,0,0,0,0,0,0,0,0,0, 5'b00000,0,0,0);

    // rows: rs1 rs2 u1 u2 rd we ld br req ack | stall freeze state count-before-edge
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,  5'b00000,0,0,0));
    vecs.push_back(mk(0,5,0,1,5,1,1,0,0,0,  5'b00111,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,  5'b00000,0,0,1));
    vecs.push_back(mk(0,0,1,1,0,1,1,0,0,0,  5'b00000,0,0,1));
    vecs.push_back(mk(7,0,0,0,7,1,1,0,0,0,  5'b00000,0,0,1));
    vecs.push_back(mk(7,0,1,0,7,0,1,0,0,0,  5'b00000,0,0,1));
    vecs.push_back(mk(7,0,1,0,7,1,0,0,0,0,  5'b00000,0,0,1));
    vecs.push_back(mk(9,0,1,0,9,1,1,0,0,0,  5'b00111,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,0,0,  5'b01100,0,0,2));
    vecs.push_back(mk(3,0,1,0,3,1,1,1,0,0,  5'b01000,0,2,3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,  5'b00000,0,0,4));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,0,  5'b10000,1,0,4));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,0,  5'b10000,1,1,5));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,0,  5'b10000,1,1,6));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,1,  5'b00000,0,1,7));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,  5'b00000,0,0,7));
    vecs.push_back(mk(4,0,1,0,4,1,1,1,1,0,  5'b10000,1,0,7));
    vecs.push_back(mk(4,0,1,0,4,1,1,1,1,1,  5'b01100,0,1,8));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,  5'b01000,0,2,9));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,  5'b00000,0,0,10));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,0,0,  5'b01100,0,0,10));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,0,  5'b10000,1,2,11));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,1,  5'b01000,0,2,12));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,  5'b00000,0,0,13));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,0,  5'b10000,1,0,13));
    vecs.push_back(mk(0,6,0,1,6,1,1,0,1,1,  5'b00111,0,1,14));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,  5'b00000,0,0,15));
    vecs.push_back(mk(31,0,1,0,31,1,1,0,0,0,5'b00111,0,0,15));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,  5'b00000,0,0,16));
    for (int k = 0; k < 5; k++) begin
      vecs.push_back(mk(12,0,1,0,12,1,1,0,0,0, 5'b00111,0,0,16 + k));
    end
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,  5'b00000,0,0,21));

    // hold reset with every hazard asserted: outputs must stay quiet
    reset = 1'b0;
    drive(mk(4,4,1,1,4,1,1,1,1,0, 5'b0,0,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_quiet(0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(idle);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // reset asserted mid-FLUSH aborts at once and leaves nothing behind
    apply(mk(0,0,0,0,0,0,0,1,0,0, 5'b01100,0,0,21), 100);
    chk("flush_entered", 101, 32'(state), 32'd2);
    reset = 1'b0;
    drive(mk(2,0,1,0,2,1,1,1,1,0, 5'b0,0,0,0));
    #2;
    chk_reset_quiet(102);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(idle);
    @(negedge clk);
    chk_reset_quiet(103);
    @(posedge clk);
    #1;

    // reset asserted mid-MEM_WAIT, then the first edge after release applies RUN rules
    apply(mk(0,0,0,0,0,0,0,0,1,0, 5'b10000,1,0,0), 110);
    apply(mk(0,0,0,0,0,0,0,0,1,0, 5'b10000,1,1,1), 111);
    reset = 1'b0;
    #2;
    chk_reset_quiet(112);
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply(mk(0,0,0,0,0,0,0,0,1,0, 5'b10000,1,0,0), 113);
    apply(mk(0,0,0,0,0,0,0,0,1,1, 5'b00000,0,1,1), 114);
    apply(mk(0,0,0,0,0,0,0,0,0,0, 5'b00000,0,0,1), 115);

    chk("scoreboard_drained", 120, 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
